// File: rtl/vliw_pkg.sv
// ---------------------------------------------------------------------------
// vliw_pkg
// Shared definitions for the VLIW issue path: bundle widths, the layout of
// the three instruction slots inside the 64-bit word, the reserved-bit mask
// and the NOP opcode.
//
// Word layout (one slot = 20 bits; slot0 at [59:40], slot1 [39:20], slot2 [19:0]):
//   [msb]      reserved
//   [msb-1 -4] opcode
//   [msb-5]    reserved
//   [msb-6 -9] src1
//   [msb-10]   reserved
//   [msb-11-14] src2
//   [msb-15]   reserved
//   [msb-16-19] dest
// Bits [63:60] above slot0 are reserved as well.
// Data layout: op1=[191:128], op2=[127:64], op3=[63:0].
// ---------------------------------------------------------------------------
package vliw_pkg;

  localparam int WORD_W   = 64;
  localparam int DATA_W   = 192;
  localparam int BUNDLE_W = WORD_W + DATA_W;

  localparam int NUM_SLOTS   = 3;
  localparam int SLOT_W      = 20;
  localparam int SLOT0_MSB   = 59;

  // Field offsets measured down from a slot's most significant bit
  localparam int OPC_OFS  = 4;
  localparam int SRC1_OFS = 9;
  localparam int SRC2_OFS = 14;
  localparam int DEST_OFS = 19;

  localparam int OP1_LSB = 128;
  localparam int OP2_LSB = 64;
  localparam int OP3_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'b0000;

  // One bit set for every reserved position: [63:60] plus the separator bit
  // in front of each 4-bit field of every slot.
  localparam logic [WORD_W-1:0] RSVD_MASK = 64'hF842_1084_2108_4210;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2
  } slot_e;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] data;
  } bundle_t;

  // Least significant bit of a field within a given slot
  function automatic int fieldLsb(input slot_e slot, input int ofs);
    return SLOT0_MSB - SLOT_W * int'(slot) - ofs;
  endfunction

  // Clears every reserved bit; an unknown reserved bit also comes out as 0
  function automatic logic [WORD_W-1:0] maskReserved(input logic [WORD_W-1:0] word);
    return word & ~RSVD_MASK;
  endfunction

  // NOP instruction word: every slot carries OP_NOP, all other fields zero
  function automatic logic [WORD_W-1:0] nopWord();
    logic [WORD_W-1:0] w;
    w = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      w[fieldLsb(slot_e'(s), OPC_OFS) +: 4] = OP_NOP;
    end
    return w;
  endfunction

endpackage

// File: rtl/vliw_bundle_fifo.sv
// ---------------------------------------------------------------------------
// vliw_bundle_fifo
// Generic DEPTH-entry storage for W-bit bundles with read/write pointers and
// an occupancy count. The caller guarantees push only when not full and pop
// only when not empty. clr empties the queue and wins over push and pop.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   push       in   write wr_bundle at the write pointer
//   pop        in   advance the read pointer
//   clr        in   discard all entries
//   wr_bundle  in   W-bit bundle to store
//   rd_bundle  out  W-bit bundle at the head
//   count      out  entries currently held
// ---------------------------------------------------------------------------
module vliw_bundle_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [W-1:0]               wr_bundle,
  output logic [W-1:0]               rd_bundle,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  // Storage is not reset; only entries below count are ever read as valid
  always_ff @(posedge clock) begin
    if (push && !clr) begin
      r_mem[r_wrPtr] <= wr_bundle;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (push && !pop)      r_count <= r_count + CNT_ONE;
      else if (pop && !push) r_count <= r_count - CNT_ONE;
    end
  end

  assign rd_bundle = r_mem[r_rdPtr];
  assign count     = r_count;

endmodule

// File: rtl/vliw_issue_queue.sv
// ---------------------------------------------------------------------------
// vliw_issue_queue
// Issue stage in front of vliw_top. Buffers bundles from the program loader
// and presents one per cycle from registered outputs. Issues a NOP bundle
// when empty, discards everything on flush (jump taken), freezes on hold and
// clears the reserved instruction-word bits before they reach vliw_top.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in_valid     in   loader offers a bundle
//   in_ready     out  bundle accepted this cycle (not full, no flush)
//   in_word      in   64-bit instruction word
//   in_data      in   192-bit immediate data
//   hold         in   downstream stall: freeze issue registers, no pop
//   flush        in   jump taken: discard queue and issue a NOP
//   issue_word   out  registered instruction word to vliw_top
//   issue_data   out  registered immediate data to vliw_top
//   issue_valid  out  1 = real bundle, 0 = injected NOP
//   count        out  entries currently queued
// ---------------------------------------------------------------------------
module vliw_issue_queue
  import vliw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_W-1:0]      in_word,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   hold,
  input  logic                   flush,
  output logic [WORD_W-1:0]      issue_word,
  output logic [DATA_W-1:0]      issue_data,
  output logic                   issue_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]     w_count;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_notEmpty;
  bundle_t           w_wrBundle;
  bundle_t           w_head;
  logic [WORD_W-1:0] r_issueWord;
  logic [DATA_W-1:0] r_issueData;
  logic              r_issueValid;

  // Ready looks only at the current count, never at a same-cycle pop, so a
  // full queue refuses new bundles even while it drains. A flush blocks
  // acceptance so nothing survives the jump.
  always_comb begin
    w_notEmpty = (w_count != '0);
    w_ready    = (w_count < FULL) && !flush;
    w_push     = in_valid && w_ready;
    w_pop      = w_notEmpty && !hold && !flush;
    w_wrBundle = '{word: in_word, data: in_data};
  end

  vliw_bundle_fifo #(
    .DEPTH (DEPTH),
    .W     (BUNDLE_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .clr       (flush),
    .wr_bundle (w_wrBundle),
    .rd_bundle (w_head),
    .count     (w_count)
  );

  // Issue registers: flush beats hold, hold freezes, otherwise the head
  // (with reserved bits cleared) or a NOP when empty. A bundle pushed into
  // an empty queue is not bypassed and issues one edge later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_issueWord  <= '0;
      r_issueData  <= '0;
      r_issueValid <= 1'b0;
    end else if (flush) begin
      r_issueWord  <= nopWord();
      r_issueData  <= '0;
      r_issueValid <= 1'b0;
    end else if (!hold) begin
      if (w_notEmpty) begin
        r_issueWord  <= maskReserved(w_head.word);
        r_issueData  <= w_head.data;
        r_issueValid <= 1'b1;
      end else begin
        r_issueWord  <= nopWord();
        r_issueData  <= '0;
        r_issueValid <= 1'b0;
      end
    end
  end

  assign in_ready    = w_ready;
  assign issue_word  = r_issueWord;
  assign issue_data  = r_issueData;
  assign issue_valid = r_issueValid;
  assign count       = w_count;

endmodule

// File: tb/tb_vliw_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_vliw_issue_queue
// Directed and randomized bench for vliw_issue_queue against a queue-based
// reference model of the issue stage.
// ---------------------------------------------------------------------------
module tb_vliw_issue_queue;

  typedef struct {
    logic [63:0]  w;
    logic [191:0] d;
  } tbBundle_t;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_word;
  logic [191:0] in_data;
  logic         hold;
  logic         flush;
  logic [63:0]  issue_word;
  logic [191:0] issue_data;
  logic         issue_valid;
  logic [2:0]   count;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  tbBundle_t    mQ[$];
  logic [63:0]  mWord;
  logic [191:0] mData;
  logic         mValid;
  logic [63:0]  rsvdMask;

  vliw_issue_queue #(.DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .in_data     (in_data),
    .hold        (hold),
    .flush       (flush),
    .issue_word  (issue_word),
    .issue_data  (issue_data),
    .issue_valid (issue_valid),
    .count       (count)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIssue(input string tag);
    checkOutput({tag, "_word"},  256'(issue_word),  256'(mWord));
    checkOutput({tag, "_data"},  256'(issue_data),  256'(mData));
    checkOutput({tag, "_valid"}, 256'(issue_valid), 256'(mValid));
    checkOutput({tag, "_count"}, 256'(count),       256'(mQ.size()));
  endtask

  // One clock cycle: drive at the falling edge, check ready, advance the
  // model across the rising edge, then check the registered outputs.
  task automatic applyStimulus(input bit v, input logic [63:0] w, input logic [191:0] d,
                               input bit h, input bit f, input string tag);
    bit expReady;
    tbBundle_t b;
    @(negedge clock);
    in_valid = v;
    in_word  = w;
    in_data  = d;
    hold     = h;
    flush    = f;
    #1;
    expReady = (mQ.size() < 4) && !f;
    checkOutput({tag, "_ready"}, 256'(in_ready), 256'(expReady));
    if (f) begin
      mQ.delete();
      mWord  = '0;
      mData  = '0;
      mValid = 1'b0;
    end else begin
      if (!h) begin
        if (mQ.size() > 0) begin
          b      = mQ.pop_front();
          mWord  = b.w & ~rsvdMask;
          mData  = b.d;
          mValid = 1'b1;
        end else begin
          mWord  = '0;
          mData  = '0;
          mValid = 1'b0;
        end
      end
      if (v && expReady) begin
        b.w = w;
        b.d = d;
        mQ.push_back(b);
      end
    end
    @(posedge clock);
    #1;
    checkIssue(tag);
  endtask

  function automatic logic [63:0] randWord();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [191:0] randData();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] w;
    int maxCount;

    // Reserved positions listed explicitly, independent of the RTL constant
    rsvdMask = '0;
    for (int b = 60; b < 64; b++) rsvdMask[b] = 1'b1;
    for (int b = 4; b <= 59; b += 5) rsvdMask[b] = 1'b1;

    mQ.delete();
    mWord = '0; mData = '0; mValid = 1'b0;
    reset = 1'b0; in_valid = 1'b0; in_word = '0; in_data = '0; hold = 1'b0; flush = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clock);
    #1;
    checkIssue("reset");
    checkOutput("reset_ready", 256'(in_ready), 256'(1));
    @(negedge clock);
    reset = 1'b1;

    // Single bundle: slot0 opcode 4'b0100, dest reg0, op1 immediate
    w = '0;
    w[58:55] = 4'b0100;
    applyStimulus(1, w, {64'h1234_5678_9abc_def0, 128'h0}, 0, 0, "single_push");
    applyStimulus(0, '0, '0, 0, 0, "single_issue");
    checkOutput("single_word_direct", 256'(issue_word), 256'(64'h0200_0000_0000_0000));
    checkOutput("single_valid_direct", 256'(issue_valid), 256'(1));
    applyStimulus(0, '0, '0, 0, 0, "single_nop");

    // Fill under hold, then a fifth offer that must be refused
    for (int i = 0; i < 4; i++) applyStimulus(1, randWord(), randData(), 1, 0, "fill");
    checkOutput("fill_count4", 256'(count), 256'(4));
    applyStimulus(1, randWord(), randData(), 1, 0, "fill_fifth");
    // Drain in order: count 3,2,1,0
    for (int i = 0; i < 4; i++) applyStimulus(0, '0, '0, 0, 0, "drain");
    checkOutput("drain_empty", 256'(count), 256'(0));

    // Reserved bits: all-ones word, only reserved positions must clear
    applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, randData(), 0, 0, "rsvd_push");
    applyStimulus(0, '0, '0, 0, 0, "rsvd_issue");
    checkOutput("rsvd_direct", 256'(issue_word), 256'(64'h07BD_EF7B_DEF7_BDEF));
    for (int i = 0; i < 4; i++) applyStimulus(1, randWord(), randData(), 0, 0, "rsvd_rand");

    // Flush with three queued, hold and an offer present
    applyStimulus(0, '0, '0, 0, 0, "pre_flush");
    applyStimulus(0, '0, '0, 0, 0, "pre_flush");
    for (int i = 0; i < 3; i++) applyStimulus(1, randWord(), randData(), 1, 0, "flush_fill");
    applyStimulus(1, randWord(), randData(), 1, 1, "flush");
    checkOutput("flush_count0", 256'(count), 256'(0));
    applyStimulus(0, '0, '0, 0, 0, "post_flush");

    // Back-to-back stream of ten bundles
    maxCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, randWord(), randData(), 0, 0, "stream");
      if (int'(count) > maxCount) maxCount = int'(count);
    end
    applyStimulus(0, '0, '0, 0, 0, "stream_tail");
    checkOutput("stream_count_le1", 256'(maxCount <= 1), 256'(1));

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, randWord(), randData(),
                    $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, "rand");
    end

    // Asynchronous reset in the middle of a cycle with a bundle in flight
    for (int i = 0; i < 2; i++) applyStimulus(1, randWord(), randData(), 1, 0, "midrst_fill");
    applyStimulus(0, '0, '0, 0, 0, "midrst_issue");
    @(negedge clock);
    in_valid = 1'b0;
    hold = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    mQ.delete();
    mWord = '0; mData = '0; mValid = 1'b0;
    checkIssue("midrst");
    checkOutput("midrst_ready", 256'(in_ready), 256'(1));
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(0, '0, '0, 0, 0, "after_rst");

    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
